// File: rtl/tqvp_dlmiles_i2c_buserr_if.sv
`default_nettype none
// ============================================================================
// Module : tqvp_dlmiles_i2c_buserr_if
// Pin, control and strobe bundle between an I2C controller and the bus monitor.
// Rev    : 1.0
// ============================================================================
interface tqvp_dlmiles_i2c_buserr_if #(
   parameter int TMO_W = 8
);
   logic             scl_i;
   logic             sda_i;
   logic             scl_oe_i;
   logic             sda_oe_i;
   logic             io_chk_en_i;
   logic [TMO_W-1:0] timeout_i;
   logic [2:0]       stb_error_o;
   logic             bus_busy_o;
   logic             start_det_o;
   logic             stop_det_o;

   modport slave (
      input  scl_i, sda_i, scl_oe_i, sda_oe_i, io_chk_en_i, timeout_i,
      output stb_error_o, bus_busy_o, start_det_o, stop_det_o
   );

   modport master (
      output scl_i, sda_i, scl_oe_i, sda_oe_i, io_chk_en_i, timeout_i,
      input  stb_error_o, bus_busy_o, start_det_o, stop_det_o
   );
endinterface
`default_nettype wire

// File: rtl/tqvp_dlmiles_i2c_buserr.sv
`default_nettype none
// ============================================================================
// Module : tqvp_dlmiles_i2c_buserr
// I2C bus monitor: START/STOP, busy, SCL-low timeout, IO and framing strobes.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample pin glitch filter.
// Rev    : 1.0
// ============================================================================
module tqvp_dlmiles_i2c_buserr #(
   parameter int SYNC_STAGES = 2,
   parameter int TMO_W       = 8,
   parameter int PRESCALE_W  = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   tqvp_dlmiles_i2c_buserr_if.slave bus
);
   localparam int CNT_W = TMO_W + PRESCALE_W;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_s, sda_s, scl_f, sda_f, scl_p, sda_p;
   logic                   scl_rise, start_c, stop_c, gen_c, io_c;
   logic                   busy, tmo_run, tmo_hit, tmo_fired;
   logic [3:0]             bit_cnt;
   logic [CNT_W-1:0]       tmo_cnt, tmo_target;
   logic                   start_det, stop_det;
   logic [2:0]             err_pipe, err_out;
   logic                   unused_scl_oe;

   // Target clock stretching is indistinguishable from our own drive here.
   assign unused_scl_oe = bus.scl_oe_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_hist, sda_hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
      end else begin
         scl_hist <= {scl_hist[0], scl_s};
         sda_hist <= {sda_hist[0], sda_s};
      end
   end

   // Follow the pin only when three consecutive samples agree, else hold.
   assign scl_f = (scl_hist == {2{scl_s}}) ? scl_s : scl_p;
   assign sda_f = (sda_hist == {2{sda_s}}) ? sda_s : sda_p;
`else
   assign scl_f = scl_s;
   assign sda_f = sda_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_p <= 1'b1;
         sda_p <= 1'b1;
      end else begin
         scl_p <= scl_f;
         sda_p <= sda_f;
      end
   end

   // SCL rising together with an SDA fall counts as both a START and a clock.
   assign scl_rise = scl_f & ~scl_p;
   assign start_c  = scl_f & sda_p & ~sda_f;
   assign stop_c   = scl_f & ~sda_p & sda_f;
   assign busy     = (state == ST_BUSY);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (start_c)     state_nx = ST_BUSY;
      else if (stop_c) state_nx = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst)
         bit_cnt <= 4'd0;
      else if (start_c || stop_c)
         bit_cnt <= 4'd0;
      else if (scl_rise && busy)
         bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
   end

   assign gen_c = (stop_c | (start_c & busy)) & (bit_cnt != 4'd0);
   assign io_c  = scl_rise & bus.io_chk_en_i & (bus.sda_oe_i ? sda_f : ~sda_f);

   assign tmo_target = {bus.timeout_i, {PRESCALE_W{1'b0}}};
   assign tmo_run    = busy & ~scl_f & (bus.timeout_i != '0);
   assign tmo_hit    = tmo_run & ~tmo_fired & (tmo_cnt == tmo_target);

   // Counter stops below or at the target so a lowered limit never wraps into a strobe.
   always_ff @(posedge clk) begin
      if (rst || !tmo_run) begin
         tmo_cnt   <= '0;
         tmo_fired <= 1'b0;
      end else if (tmo_hit) begin
         tmo_fired <= 1'b1;
      end else if (!tmo_fired && (tmo_cnt < tmo_target)) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   // Error strobes trail the START/STOP strobes by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         err_pipe  <= 3'b000;
         err_out   <= 3'b000;
      end else begin
         start_det <= start_c;
         stop_det  <= stop_c;
         err_pipe  <= {tmo_hit, io_c, gen_c};
         err_out   <= err_pipe;
      end
   end

   assign bus.stb_error_o = err_out;
   assign bus.bus_busy_o  = busy;
   assign bus.start_det_o = start_det;
   assign bus.stop_det_o  = stop_det;
endmodule
`default_nettype wire

// File: tb/tb_tqvp_dlmiles_i2c_buserr.sv
`default_nettype none
// ============================================================================
// Module : tb_tqvp_dlmiles_i2c_buserr
// Directed self-checking bench for the I2C bus condition monitor.
// Rev    : 1.0
// ============================================================================
module tb_tqvp_dlmiles_i2c_buserr;
   localparam int SYNC_STAGES = 2;
   localparam int TMO_W       = 8;
   localparam int PRESCALE_W  = 2;
`ifdef I2C_GLITCH_FILTER_EN
   localparam int LAT = SYNC_STAGES + 3;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif
   localparam int H = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   n_start = 0, n_stop = 0, n_gen = 0, n_io = 0, n_tmo = 0;
   logic [2:0] last_err = 3'b000;

   tqvp_dlmiles_i2c_buserr_if #(.TMO_W(TMO_W)) bus ();

   tqvp_dlmiles_i2c_buserr #(
      .SYNC_STAGES(SYNC_STAGES),
      .TMO_W      (TMO_W),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.start_det_o)    n_start++;
      if (bus.stop_det_o)     n_stop++;
      if (bus.stb_error_o[0]) n_gen++;
      if (bus.stb_error_o[1]) n_io++;
      if (bus.stb_error_o[2]) n_tmo++;
      if (bus.stb_error_o != 3'b000) last_err = bus.stb_error_o;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic scl, input logic sda, input int n);
      bus.scl_i = scl;
      bus.sda_i = sda;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      drive(1'b1, 1'b0, H);
      drive(1'b0, 1'b0, H);
   endtask

   task automatic do_bit(input logic b);
      drive(1'b0, b, H);
      drive(1'b1, b, H);
      drive(1'b0, b, H);
   endtask

   task automatic do_stop();
      drive(1'b0, 1'b0, H);
      drive(1'b1, 1'b0, H);
      drive(1'b1, 1'b1, H);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.stb_error_o, bus.bus_busy_o, bus.start_det_o, bus.stop_det_o} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b, expected 000000",
                  {bus.stb_error_o, bus.bus_busy_o, bus.start_det_o, bus.stop_det_o});
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if ({bus.stb_error_o, bus.bus_busy_o, n_start, n_stop} !== {4'b0, 32'd0, 32'd0}) begin
         failures++;
         $display("FAIL reset_idle: err=%b busy=%b starts=%0d stops=%0d, expected all 0",
                  bus.stb_error_o, bus.bus_busy_o, n_start, n_stop);
      end
   endtask

   task automatic test_byte();
      int s0, p0, e0;
      s0 = n_start; p0 = n_stop; e0 = n_gen + n_io + n_tmo;
      do_start();
      checks++;
      if (bus.bus_busy_o !== 1'b1) begin
         failures++;
         $display("FAIL byte_busy_set: got %b, expected 1", bus.bus_busy_o);
      end
      // Eight data clocks here; the STOP's own SCL rise is the ninth clock.
      for (int i = 0; i < 8; i++) do_bit(1'b1);
      do_stop();
      checks++;
      if ((n_start - s0) !== 1 || (n_stop - p0) !== 1) begin
         failures++;
         $display("FAIL byte_start_stop: got starts=%0d stops=%0d, expected 1 1",
                  n_start - s0, n_stop - p0);
      end
      checks++;
      if ((n_gen + n_io + n_tmo - e0) !== 0) begin
         failures++;
         $display("FAIL byte_no_error: got %0d error strobes, expected 0", n_gen + n_io + n_tmo - e0);
      end
      checks++;
      if (bus.bus_busy_o !== 1'b0) begin
         failures++;
         $display("FAIL byte_busy_clear: got %b, expected 0", bus.bus_busy_o);
      end
   endtask

   task automatic test_generic();
      int k;
      k = 0;
      do_start();
      for (int i = 0; i < 4; i++) do_bit(1'b0);
      drive(1'b0, 1'b0, H);
      drive(1'b1, 1'b0, H);
      bus.sda_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.stop_det_o) begin
            k = i;
            break;
         end
      end
      checks++;
      if (k !== LAT) begin
         failures++;
         $display("FAIL generic_stop_latency: got %0d, expected %0d", k, LAT);
      end
      @(negedge clk);
      checks++;
      if (bus.stb_error_o !== 3'b001) begin
         failures++;
         $display("FAIL generic_strobe: got %b, expected 001", bus.stb_error_o);
      end
      repeat (H) @(negedge clk);
      checks++;
      if (bus.bus_busy_o !== 1'b0) begin
         failures++;
         $display("FAIL generic_busy_clear: got %b, expected 0", bus.bus_busy_o);
      end
   endtask

   task automatic test_timeout();
      int t0, k;
      logic [2:0] v;
      k = 0;
      v = 3'b000;
      bus.timeout_i = 8'd3;
      drive(1'b1, 1'b0, H);
      t0 = n_tmo;
      bus.scl_i = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.stb_error_o[2]) begin
            k = i;
            v = bus.stb_error_o;
            break;
         end
      end
      checks++;
      if (k !== LAT + 13 || v !== 3'b100) begin
         failures++;
         $display("FAIL timeout_first: got latency=%0d err=%b, expected latency=%0d err=100",
                  k, v, LAT + 13);
      end
      repeat (20) @(negedge clk);
      checks++;
      if ((n_tmo - t0) !== 1) begin
         failures++;
         $display("FAIL timeout_single: got %0d strobes, expected 1", n_tmo - t0);
      end
      drive(1'b1, 1'b0, H);
      drive(1'b0, 1'b0, 25);
      checks++;
      if ((n_tmo - t0) !== 2) begin
         failures++;
         $display("FAIL timeout_refire: got %0d strobes, expected 2", n_tmo - t0);
      end
      bus.timeout_i = 8'd10;
      drive(1'b1, 1'b0, H);
      drive(1'b0, 1'b0, 20);
      bus.timeout_i = 8'd1;
      drive(1'b0, 1'b0, 20);
      checks++;
      if ((n_tmo - t0) !== 2) begin
         failures++;
         $display("FAIL timeout_lowered: got %0d strobes, expected 2", n_tmo - t0);
      end
      drive(1'b1, 1'b0, H);
      drive(1'b0, 1'b0, 20);
      checks++;
      if ((n_tmo - t0) !== 3) begin
         failures++;
         $display("FAIL timeout_small: got %0d strobes, expected 3", n_tmo - t0);
      end
      bus.timeout_i = 8'd0;
      drive(1'b0, 1'b0, 30);
      checks++;
      if ((n_tmo - t0) !== 3) begin
         failures++;
         $display("FAIL timeout_disabled: got %0d strobes, expected 3", n_tmo - t0);
      end
      drive(1'b0, 1'b1, H);
      drive(1'b1, 1'b1, H);
      pulse_rst();
   endtask

   task automatic test_io();
      int i0, g0;
      do_start();
      i0 = n_io; g0 = n_gen;
      bus.io_chk_en_i = 1'b1;
      bus.sda_oe_i = 1'b0;
      do_bit(1'b0);
      bus.sda_oe_i = 1'b1;
      do_bit(1'b0);
      bus.sda_oe_i = 1'b0;
      do_bit(1'b1);
      bus.sda_oe_i = 1'b1;
      do_bit(1'b1);
      bus.io_chk_en_i = 1'b0;
      bus.sda_oe_i = 1'b0;
      do_bit(1'b0);
      checks++;
      if ((n_io - i0) !== 2 || (n_gen - g0) !== 0) begin
         failures++;
         $display("FAIL io_count: got io=%0d gen=%0d, expected io=2 gen=0", n_io - i0, n_gen - g0);
      end
      checks++;
      if (last_err !== 3'b010) begin
         failures++;
         $display("FAIL io_value: got %b, expected 010", last_err);
      end
   endtask

   task automatic test_rst_mid();
      int p0, g0;
      pulse_rst();
      checks++;
      if (bus.bus_busy_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_busy: got %b, expected 0", bus.bus_busy_o);
      end
      p0 = n_stop; g0 = n_gen;
      do_stop();
      checks++;
      if ((n_stop - p0) !== 1 || (n_gen - g0) !== 0) begin
         failures++;
         $display("FAIL rst_mid_stop: got stops=%0d gen=%0d, expected 1 0", n_stop - p0, n_gen - g0);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      k = 0;
      do_start();
      for (int i = 0; i < 5; i++) do_bit(1'b1);
      bus.io_chk_en_i = 1'b1;
      bus.sda_oe_i = 1'b0;
      bus.scl_i = 1'b1;
      bus.sda_i = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.start_det_o) begin
            k = i;
            break;
         end
      end
      checks++;
      if (k !== LAT) begin
         failures++;
         $display("FAIL rstart_latency: got %0d, expected %0d", k, LAT);
      end
      @(negedge clk);
      checks++;
      if (bus.stb_error_o !== 3'b011 || bus.bus_busy_o !== 1'b1) begin
         failures++;
         $display("FAIL rstart_errors: got err=%b busy=%b, expected err=011 busy=1",
                  bus.stb_error_o, bus.bus_busy_o);
      end
      bus.io_chk_en_i = 1'b0;
      drive(1'b1, 1'b0, H);
      drive(1'b0, 1'b0, H);
      drive(1'b0, 1'b1, H);
      drive(1'b1, 1'b1, H);
      pulse_rst();
   endtask

   task automatic test_glitch();
      int s0, p0;
      s0 = n_start; p0 = n_stop;
`ifdef I2C_GLITCH_FILTER_EN
      drive(1'b1, 1'b0, 2);
      drive(1'b1, 1'b1, 12);
      checks++;
      if ((n_start - s0) !== 0) begin
         failures++;
         $display("FAIL glitch_2clk: got %0d starts, expected 0", n_start - s0);
      end
      drive(1'b1, 1'b0, 3);
      drive(1'b1, 1'b1, 12);
`else
      drive(1'b1, 1'b0, 1);
      drive(1'b1, 1'b1, 12);
`endif
      checks++;
      if ((n_start - s0) !== 1 || (n_stop - p0) !== 1 || bus.bus_busy_o !== 1'b0) begin
         failures++;
         $display("FAIL glitch_pass: got starts=%0d stops=%0d busy=%b, expected 1 1 0",
                  n_start - s0, n_stop - p0, bus.bus_busy_o);
      end
   endtask

   initial begin
      bus.scl_i = 1'b1;
      bus.sda_i = 1'b1;
      bus.scl_oe_i = 1'b0;
      bus.sda_oe_i = 1'b0;
      bus.io_chk_en_i = 1'b0;
      bus.timeout_i = 8'd0;
      test_reset();
      test_byte();
      test_generic();
      test_timeout();
      test_io();
      test_rst_mid();
      test_back_to_back();
      test_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
